masked_sbox_sched: RTL
======================

// Module: masked_sbox_sched
// PURPOSE
//  Issue scheduler for the fixed-latency masked S-box pipeline built from HPC2 gadgets.
//  - Issues one request per cycle into the pipeline, only when a fresh randomness word is available.
//  - The pipeline never stalls, so the scheduler tracks each in-flight op with a valid/tag delay line.
//  - Gates issue with a credit counter for the downstream share buffer.
//  - Controls only: share data travels beside it in the pipeline.
// PARAMETERS
//  LAT      4  pipeline latency in cycles, issue to result (>=1)
//  TAG_W    2  width of request tag carried alongside the op
//  CREDITS  4  downstream buffer slots (>=1); counter width $clog2(CREDITS+1)
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-high
//  in_valid    in   1      request present
//  in_ready    out  1      request accepted this cycle (when in_valid)
//  in_tag      in   TAG_W  request tag
//  rnd_valid   in   1      PRNG word available
//  rnd_ready   out  1      PRNG word consumed this cycle (when rnd_valid)
//  pipe_issue  out  1      strobe: load shares + randomness into pipeline stage 0
//  pipe_tag    out  TAG_W  tag of issued op (= in_tag)
//  out_valid   out  1      pipeline result valid (pulse, no backpressure)
//  out_tag     out  TAG_W  tag of result
//  credit_ret  in   1      downstream freed one slot
//  busy        out  1      inflight != 0
//  err         out  1      sticky: credit overflow (return at CREDITS)
//  flush       in   1      (SCHED_FLUSH_EN only) stop accepting and drain
//  flush_done  out  1      (SCHED_FLUSH_EN only) 1-cycle pulse when drained
// BEHAVIOUR
//  - Issue condition: can = (state==RUN) & (credits!=0).
//    issue = in_valid & rnd_valid & can.
//  - Ready outputs must not depend on own valid:
//    in_ready = rnd_valid & can; rnd_ready = in_valid & can.
//    Request and randomness are consumed only together.
//  - pipe_issue = issue; pipe_tag = in_tag (combinational).
//  - Delay line: LAT regs of {v,tag}. Issue at cycle t -> out_valid=1, out_tag=tag at t+LAT.
//  - credits: -1 on issue, +1 on credit_ret; both in the same cycle -> unchanged.
//    credit_ret at credits==CREDITS: ignored, err<=1 (sticky until rst).
//  - inflight: +1 on issue, -1 on out_valid, net 0 if both; max LAT.
//  - FSM states RUN, DRAIN. Reset -> RUN.
//    RUN -> DRAIN on flush (flush cycle itself issues nothing).
//    DRAIN -> RUN when inflight==0, with flush_done=1 that cycle.
//  - Reset values: delay line cleared, credits=CREDITS, inflight=0, err=0, state=RUN.
//    All registered outputs 0 at reset.
//  - rst mid-operation: in-flight ops are dropped, so no out_valid for them; credits restored.
// CONFIGURATION
//  SCHED_FLUSH_EN defined:
//  - flush/flush_done ports and the DRAIN state exist.
//  SCHED_FLUSH_EN undefined:
//  - ports absent; state is constant RUN; can = (credits!=0).
// STRUCTURE
//  Package masked_sbox_sched_pkg: state enum {RUN, DRAIN}; localparam CRED_W helper function.
//  Sub-module masked_sbox_sched_dly: parameterised LAT x (1+TAG_W) shift line with sync clear.
//  Top contains the FSM, credit counter, inflight counter and err flag.
// TESTING
//  1. Reset, then in_valid=1, rnd_valid=1, tags 0,1,2,3 on consecutive cycles ->
//     4 issues; out_valid at cycles 4..7 with tags 0..3; in_ready=0 on 5th cycle (credits 0).
//  2. in_valid=1, rnd_valid=0 for 3 cycles, then 1 ->
//     no issue and rnd_ready=1, in_ready=0 while stalled; a single issue when rnd_valid rises.
//  3. credits=0 and credit_ret=1 with pending request ->
//     issue next cycle; then issue and credit_ret in the same cycle -> credits stays 1.
//  4. credit_ret at credits=4 -> credits stays 4, err=1 and held after further traffic.
//  5. (FLUSH_EN) 2 ops in flight, flush=1 ->
//     in_ready=0 from that cycle; flush_done pulses the cycle the last out_valid retires; then RUN.
//  6. rst asserted with 3 ops in flight -> no out_valid afterwards, credits=4, busy=0.

Source files
------------

// File: rtl/masked_sbox_sched_pkg.sv
// Shared types and sizing helpers for the masked S-box issue scheduler.
package masked_sbox_sched_pkg;

  typedef enum logic [0:0] {StRun, StDrain} sched_state_e;

  // Bits needed to hold any count 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/masked_sbox_sched_if.sv
// Request/randomness/result/credit bundle of the scheduler.
// The flush pair exists only when SCHED_FLUSH_EN is defined.
interface masked_sbox_sched_if #(
  parameter int unsigned TAG_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic             rnd_valid;
  logic             rnd_ready;
  logic             pipe_issue;
  logic [TAG_W-1:0] pipe_tag;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic             credit_ret;
  logic             busy;
  logic             err;
`ifdef SCHED_FLUSH_EN
  logic             flush;
  logic             flush_done;

  modport slave (
    input  in_valid, in_tag, rnd_valid, credit_ret, flush,
    output in_ready, rnd_ready, pipe_issue, pipe_tag, out_valid, out_tag, busy, err, flush_done
  );
  modport master (
    output in_valid, in_tag, rnd_valid, credit_ret, flush,
    input  in_ready, rnd_ready, pipe_issue, pipe_tag, out_valid, out_tag, busy, err, flush_done
  );
`else
  modport slave (
    input  in_valid, in_tag, rnd_valid, credit_ret,
    output in_ready, rnd_ready, pipe_issue, pipe_tag, out_valid, out_tag, busy, err
  );
  modport master (
    output in_valid, in_tag, rnd_valid, credit_ret,
    input  in_ready, rnd_ready, pipe_issue, pipe_tag, out_valid, out_tag, busy, err
  );
`endif
endinterface

// File: rtl/masked_sbox_sched_dly.sv
// LAT-deep shift line of {valid, tag} tracking ops through the non-stalling pipeline.
module masked_sbox_sched_dly #(
  parameter int unsigned LAT = 4,
  parameter int unsigned W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] line_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT); i++) begin
        line_q[i] <= '0;
      end
    end else begin
      line_q[0] <= din;
      for (int i = 1; i < int'(LAT); i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign dout = line_q[LAT-1];

endmodule

// File: rtl/masked_sbox_sched.sv
// Issue scheduler for the fixed-latency masked S-box pipeline: credit-gated, randomness-paced.
// Optional drain/flush control is built when SCHED_FLUSH_EN is defined.
module masked_sbox_sched
  import masked_sbox_sched_pkg::*;
#(
  parameter int unsigned LAT     = 4,
  parameter int unsigned TAG_W   = 2,
  parameter int unsigned CREDITS = 4
) (
  input logic               clk,
  input logic               rst,
  masked_sbox_sched_if.slave bus
);

  localparam int unsigned CRED_W = cnt_w(CREDITS);
  localparam int unsigned INFL_W = cnt_w(LAT);
  localparam logic [CRED_W-1:0] CredMax = CRED_W'(CREDITS);

  sched_state_e      state_q;
  logic              flush_req;
  logic              can_issue;
  logic              issue;
  logic              out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic [INFL_W-1:0] inflight_q, inflight_d;
  logic              err_q, err_d;

`ifdef SCHED_FLUSH_EN
  sched_state_e state_d;
  logic         flush_done;

  assign flush_req = bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Drained once the op retiring this cycle is the last one in flight.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      StRun:   if (flush_req) state_d = StDrain;
      StDrain: begin
        if (inflight_d == '0) begin
          state_d    = StRun;
          flush_done = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign bus.flush_done = flush_done;
`else
  assign flush_req = 1'b0;
  assign state_q   = StRun;
`endif

  // Readies look only at the other side's valid so neither is consumed alone.
  assign can_issue     = (state_q == StRun) && (credits_q != '0) && !flush_req;
  assign issue         = bus.in_valid && bus.rnd_valid && can_issue;
  assign bus.in_ready  = bus.rnd_valid && can_issue;
  assign bus.rnd_ready = bus.in_valid && can_issue;
  assign bus.pipe_issue = issue;
  assign bus.pipe_tag   = bus.in_tag;

  masked_sbox_sched_dly #(
    .LAT (LAT),
    .W   (1 + TAG_W)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({issue, bus.in_tag}),
    .dout ({out_valid, out_tag})
  );

  assign bus.out_valid = out_valid;
  assign bus.out_tag   = out_tag;

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !out_valid) begin
      inflight_d = inflight_q + INFL_W'(1);
    end else if (!issue && out_valid) begin
      inflight_d = inflight_q - INFL_W'(1);
    end
  end

  // A return with every slot already free is dropped and flagged.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (issue && !bus.credit_ret) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!issue && bus.credit_ret) begin
      if (credits_q == CredMax) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q  <= CredMax;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign bus.busy = (inflight_q != '0);
  assign bus.err  = err_q;

endmodule
